axis_pkt_tx: RTL and testbench

AXIS_PKT_TX -- requirements
Module: axis_pkt_tx

---
 rtl/axis_pkt_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_axis_pkt_tx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_tx.sv
// -----------------------------------------------------------------------------
// axis_pkt_tx
//
// Packet transmitter. A host fills a byte buffer and then posts
// {start address, length} commands. Each command is replayed as one
// AXI-Stream packet, one byte per beat. After every packet the stream is
// held idle for IFG cycles.
//
// Parameters
//   ADDR_WIDTH  log2 of the packet buffer size in bytes
//   IFG         idle cycles inserted after each packet's final handshake
//   CMD_DEPTH   command queue entries (power of 2, >= 2)
//
// Ports
//   aclk, aresetn        clock (rising edge) and asynchronous active-low reset
//   buf_we/waddr/wdata   buffer byte write port, always accepted
//   cmd_valid/ready      command handshake; ready while the queue has room
//   cmd_addr, cmd_len    packet start address and length in bytes
//   cmd_err              one-cycle pulse when an illegal command is dropped
//   m_axis_*             AXI-Stream byte master (tdata/tvalid/tlast/tready)
//   tx_busy              transmitter is not idle
//   tx_pkt_cnt           count of fully sent packets, wraps at 16 bits
// -----------------------------------------------------------------------------
module axis_pkt_tx #(
    parameter int ADDR_WIDTH = 9,
    parameter int IFG        = 12,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  buf_we,
    input  logic [ADDR_WIDTH-1:0] buf_waddr,
    input  logic [7:0]            buf_wdata,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  cmd_err,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  tx_busy,
    output logic [15:0]           tx_pkt_cnt
);

    localparam int DEPTH_BYTES = 1 << ADDR_WIDTH;
    localparam int PW          = $clog2(CMD_DEPTH);
    localparam int GW          = $clog2(IFG + 1) + 1;

    localparam logic [ADDR_WIDTH:0] MAX_LEN  = (ADDR_WIDTH+1)'(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);
    localparam logic [PW:0]         DEPTH_C  = (PW+1)'(CMD_DEPTH);
    localparam logic [GW-1:0]       GAP_LOAD = (IFG > 0) ? GW'(IFG - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA,
        GAP
    } state_t;

    state_t state;
    state_t state_next;

    // ---------------------------------------------------------------------
    // Packet buffer: simple dual-port RAM with a registered read port.
    // The read register keeps its value while no read is issued, which is
    // what holds tdata stable under backpressure.
    // ---------------------------------------------------------------------
    logic [7:0]            mem [DEPTH_BYTES];
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [7:0]            rd_data_p1;

    always_ff @(posedge aclk) begin
        if (buf_we) begin
            mem[buf_waddr] <= buf_wdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_data_p1 <= '0;
        end else if (ram_re) begin
            rd_data_p1 <= mem[ram_raddr];
        end
    end

    // ---------------------------------------------------------------------
    // Command queue
    // ---------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] q_addr [CMD_DEPTH];
    logic [ADDR_WIDTH:0]   q_len  [CMD_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           q_count;
    logic                  q_empty;
    logic                  cmd_fire;
    logic                  cmd_legal;
    logic                  push;
    logic                  pop;

    // cmd_ready looks only at the pre-pop occupancy, so a full queue never
    // accepts a push even in the cycle it is being popped.
    assign cmd_ready = (q_count < DEPTH_C);
    assign q_empty   = (q_count == '0);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_legal = (cmd_len != '0) && (cmd_len <= MAX_LEN);
    assign push      = cmd_fire && cmd_legal;

    always_ff @(posedge aclk) begin
        if (push) begin
            q_addr[wr_ptr] <= cmd_addr;
            q_len[wr_ptr]  <= cmd_len;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= cmd_fire && !cmd_legal;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Transmit FSM
    // ---------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   remain;
    logic [GW-1:0]         gap_cnt;
    logic                  beat_done;
    logic                  last_beat;

    assign beat_done = (state == DATA) && m_axis_tready;
    assign last_beat = (remain == ONE);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        ram_re     = 1'b0;
        ram_raddr  = rd_addr;
        case (state)
            IDLE: begin
                if (!q_empty) begin
                    pop        = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                ram_re     = 1'b1;
                state_next = DATA;
            end
            DATA: begin
                if (m_axis_tready) begin
                    if (last_beat) begin
                        state_next = (IFG > 0) ? GAP : IDLE;
                    end else begin
                        // Prefetch the next byte so it is presented on the
                        // very next cycle; the address wraps at buffer end.
                        ram_re    = 1'b1;
                        ram_raddr = rd_addr + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            rd_addr    <= '0;
            remain     <= '0;
            gap_cnt    <= '0;
            tx_pkt_cnt <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                rd_addr <= q_addr[rd_ptr];
                remain  <= q_len[rd_ptr];
            end
            if (beat_done) begin
                if (last_beat) begin
                    tx_pkt_cnt <= tx_pkt_cnt + 1'b1;
                    gap_cnt    <= GAP_LOAD;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                    remain  <= remain - 1'b1;
                end
            end
            if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    assign m_axis_tdata  = rd_data_p1;
    assign m_axis_tvalid = (state == DATA);
    assign m_axis_tlast  = (state == DATA) && last_beat;
    assign tx_busy       = (state != IDLE);

endmodule

// File: tb/tb_axis_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_tx
//
// Directed bench for axis_pkt_tx. The buffer is loaded with a known pattern
// (byte at address a = a[7:0] with bit 7 flipped for the upper half), a table
// of packet commands is replayed against it, and hand-written sequences
// cover queue-full/inter-frame spacing and reset in the middle of a packet.
// -----------------------------------------------------------------------------
module tb_axis_pkt_tx;

    localparam int AW    = 9;
    localparam int IFG   = 12;
    localparam int DEPTH = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [7:0]    buf_wdata;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          cmd_err;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          tx_busy;
    logic [15:0]   tx_pkt_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [8:0] addr;
        logic [9:0] len;
        bit         toggle;
        bit         exp_err;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } pkt_vec_t;

    pkt_vec_t vecs[7];

    axis_pkt_tx #(
        .ADDR_WIDTH(AW),
        .IFG       (IFG),
        .CMD_DEPTH (DEPTH)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .buf_we       (buf_we),
        .buf_waddr    (buf_waddr),
        .buf_wdata    (buf_wdata),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_err      (cmd_err),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .tx_busy      (tx_busy),
        .tx_pkt_cnt   (tx_pkt_cnt)
    );

    always #5 aclk = ~aclk;

    function automatic logic [7:0] pat(input logic [8:0] a);
        return a[7:0] ^ {a[8], 7'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vec_cnt++;
        if (act !== want) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Posts one command, follows it to completion and checks every beat.
    task automatic run_pkt(input pkt_vec_t v);
        int         beats   = 0;
        int         first_k = 0;
        int         last_k  = 0;
        int         waitc   = 0;
        bit         holding = 0;
        bit         ok;
        logic [7:0] hold_d    = 8'h00;
        logic       hold_l    = 1'b0;
        logic [7:0] got_first = 8'h00;
        logic [7:0] got_last  = 8'h00;
        logic [8:0] a;

        @(posedge aclk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        @(negedge aclk);
        while (!cmd_ready && waitc < 20) begin
            @(negedge aclk);
            waitc++;
        end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        chk("cmd_err", cmd_err, v.exp_err);

        if (v.exp_err) begin
            @(posedge aclk); #1;
            chk("cmd_err_pulse", cmd_err, 0);
            ok = 1;
            repeat (16) begin
                @(negedge aclk);
                if (m_axis_tvalid) ok = 0;
            end
            chk("illegal_no_tvalid", ok, 1);
            chk("illegal_cnt", tx_pkt_cnt, exp_cnt);
            return;
        end

        for (int k = 0; (k < 2 * v.len + IFG + 40) && (beats < v.len); k++) begin
            m_axis_tready = v.toggle ? ((k % 2) == 0) : 1'b1;
            @(negedge aclk);
            if (holding) begin
                chk("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, hold_l, hold_d});
                holding = 0;
            end
            if (m_axis_tvalid && !m_axis_tready) begin
                holding = 1;
                hold_d  = m_axis_tdata;
                hold_l  = m_axis_tlast;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                a = v.addr + 9'(beats);
                chk("beat_data", m_axis_tdata, pat(a));
                chk("beat_last", m_axis_tlast, (beats == v.len - 1));
                if (beats == 0) begin
                    got_first = m_axis_tdata;
                    first_k   = k;
                end
                got_last = m_axis_tdata;
                last_k   = k;
                beats++;
            end
            @(posedge aclk); #1;
        end
        m_axis_tready = 1'b1;

        chk("beat_count", beats, v.len);
        chk("first_byte", got_first, v.exp_first);
        chk("last_byte", got_last, v.exp_last);
        if (!v.toggle) chk("burst_cycles", last_k - first_k, v.len - 1);
        chk("tvalid_after_last", m_axis_tvalid, 0);
        exp_cnt++;
        chk("pkt_cnt", tx_pkt_cnt, exp_cnt);
    endtask

    task automatic push_cmd(input logic [8:0] addr, input logic [9:0] len);
        int w = 0;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge aclk);
        while (!cmd_ready && w < 40) begin
            @(negedge aclk);
            w++;
        end
        chk("push_ready", cmd_ready, 1);
        @(posedge aclk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pkt_vec_t v;
        bit       ok;
        bit       hit;
        int       pkts;
        int       t1;
        int       t2;
        int       beats;

        // addr, len, toggle tready, expect cmd_err, first byte, last byte
        vecs[0] = '{9'd0,   10'd64,  1'b0, 1'b0, 8'h00, 8'h3F};
        vecs[1] = '{9'd510, 10'd4,   1'b0, 1'b0, 8'h7E, 8'h01};
        vecs[2] = '{9'd100, 10'd8,   1'b1, 1'b0, 8'h64, 8'h6B};
        vecs[3] = '{9'd0,   10'd0,   1'b0, 1'b1, 8'h00, 8'h00};
        vecs[4] = '{9'd0,   10'd513, 1'b0, 1'b1, 8'h00, 8'h00};
        vecs[5] = '{9'd300, 10'd1,   1'b0, 1'b0, 8'hAC, 8'hAC};
        vecs[6] = '{9'd0,   10'd512, 1'b0, 1'b0, 8'h00, 8'h7F};

        aresetn       = 1'b0;
        buf_we        = 1'b0;
        buf_waddr     = '0;
        buf_wdata     = '0;
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_len       = '0;
        m_axis_tready = 1'b1;

        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_pkt_cnt", tx_pkt_cnt, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_cmd_ready", cmd_ready, 1);

        // Buffer load
        for (int a = 0; a < 512; a++) begin
            @(posedge aclk); #1;
            buf_we    = 1'b1;
            buf_waddr = 9'(a);
            buf_wdata = pat(9'(a));
        end
        @(posedge aclk); #1;
        buf_we = 1'b0;

        // Table-driven packets
        for (int i = 0; i < 7; i++) begin
            run_pkt(vecs[i]);
        end

        // Queue full and inter-frame spacing. With tready low the first
        // packet is stuck in DATA, so four more commands fill the queue.
        repeat (30) @(posedge aclk);
        #1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(9'(16 * i), 10'd2);
        end
        chk("queue_full", cmd_ready, 0);
        cmd_addr = 9'd200;
        cmd_len  = 10'd2;
        ok = 1;
        repeat (4) begin
            @(negedge aclk);
            if (cmd_ready) ok = 0;
        end
        chk("full_stays_not_ready", ok, 1);
        @(posedge aclk); #1;
        cmd_valid     = 1'b0;
        m_axis_tready = 1'b1;

        // tlast handshake in cycle t1 -> GAP for IFG cycles, one IDLE cycle
        // (pop), one FETCH cycle, so the next tvalid is at t1 + IFG + 3 and
        // the pop frees a queue slot visible at t1 + IFG + 2.
        pkts = 0;
        t1   = -1;
        t2   = -1;
        for (int k = 0; (k < 400) && (pkts < 5); k++) begin
            @(negedge aclk);
            if (t1 >= 0 && t2 < 0 && m_axis_tvalid) t2 = k;
            if (t1 >= 0 && k == t1 + 1) chk("ready_low_in_gap", cmd_ready, 0);
            if (t1 >= 0 && k == t1 + IFG + 2) chk("ready_after_pop", cmd_ready, 1);
            if (m_axis_tvalid && m_axis_tlast) begin
                pkts++;
                if (pkts == 1) t1 = k;
            end
            @(posedge aclk); #1;
        end
        chk("queue_pkts", pkts, 5);
        chk("ifg_spacing", t2 - t1, IFG + 3);
        ok = 1;
        repeat (30) begin
            @(negedge aclk);
            if (m_axis_tvalid) ok = 0;
        end
        chk("rejected_cmd_not_sent", ok, 1);
        exp_cnt += 5;
        chk("queue_pkt_cnt", tx_pkt_cnt, exp_cnt);
        chk("queue_idle", tx_busy, 0);

        // Reset on the third beat of a 10-byte packet
        @(posedge aclk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = 9'd0;
        cmd_len   = 10'd10;
        @(posedge aclk); #1;
        cmd_valid     = 1'b0;
        m_axis_tready = 1'b1;
        beats = 0;
        hit   = 0;
        for (int k = 0; (k < 40) && !hit; k++) begin
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                if (beats == 3) begin
                    aresetn = 1'b0;
                    #1;
                    hit = 1;
                    chk("midrst_tvalid", m_axis_tvalid, 0);
                    chk("midrst_tlast", m_axis_tlast, 0);
                    chk("midrst_busy", tx_busy, 0);
                    chk("midrst_pkt_cnt", tx_pkt_cnt, 0);
                    chk("midrst_tdata", m_axis_tdata, 0);
                end
            end
            if (!hit) begin
                @(posedge aclk); #1;
            end
        end
        chk("midrst_reached", hit, 1);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("midrst_cmd_ready", cmd_ready, 1);
        exp_cnt = 0;
        ok = 1;
        repeat (8) begin
            @(negedge aclk);
            if (m_axis_tvalid) ok = 0;
        end
        chk("aborted_pkt_silent", ok, 1);
        v = '{9'd7, 10'd1, 1'b0, 1'b0, 8'h07, 8'h07};
        run_pkt(v);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
